// File: rtl/image_loader_if.sv
// Byte-stream / data-memory bus for image_loader: serial bytes in, memory writes and status out.
interface image_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wd, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wd, busy, done, err
  );
endinterface

// File: rtl/image_loader.sv
// Streams IMG_BYTES serial bytes into data memory starting at BASE_ADDR.
// Optional trailing checksum byte verification: define LOADER_CHECKSUM_EN.
module image_loader #(
  parameter int unsigned IMG_BYTES = 152100,
  parameter logic [31:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  image_loader_if.slave bus
);

  localparam int unsigned CW = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic           r_we;
  logic [31:0]    r_addr;
  logic [31:0]    r_wd;
  logic           r_busy;
  logic           r_done;
  logic           w_ready;
  logic           w_accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]     r_sum;
  logic           r_err;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign w_ready = (r_state == LOAD) || (r_state == CHECK);
`else
  assign w_ready = (r_state == LOAD);
`endif
  assign w_accept = bus.in_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= LOAD;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= '0;
            r_err   <= 1'b0;
`endif
          end else begin
            // busy outlives LOAD by one cycle to cover the final write pulse
            r_busy <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_we   <= 1'b1;
            r_addr <= BASE_ADDR + 32'(r_count);
            r_wd   <= {24'b0, bus.in_data};
`ifdef LOADER_CHECKSUM_EN
            r_sum  <= r_sum + bus.in_data;
`endif
            if (r_count == LAST) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= CHECK;
`else
              r_state <= DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (w_accept) begin
            r_err   <= (bus.in_data != r_sum);
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.mem_we   = r_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wd   = r_wd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
`ifdef LOADER_CHECKSUM_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with IMG_BYTES=4, BASE_ADDR=100; checksum cases run when
// LOADER_CHECKSUM_EN is defined.
module tb_image_loader;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  image_loader_if bus();

  image_loader #(.IMG_BYTES(4), .BASE_ADDR(32'd100)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ready", 32'(bus.in_ready), 32'd1);
    check("start_busy",  32'(bus.busy),     32'd1);
    check("start_done",  32'(bus.done),     32'd0);
    check("start_err",   32'(bus.err),      32'd0);
  endtask

  task automatic send(input logic [7:0] b, input logic [31:0] addr);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    check("wr_we",   32'(bus.mem_we), 32'd1);
    check("wr_addr", bus.mem_addr,    addr);
    check("wr_wd",   bus.mem_wd,      {24'b0, b});
    check("wr_busy", 32'(bus.busy),   32'd1);
  endtask

  task automatic finish(input logic [7:0] trailer, input logic exp_err);
`ifdef LOADER_CHECKSUM_EN
    check("chk_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = trailer;
    tick();
    bus.in_valid = 1'b0;
    check("chk_no_we", 32'(bus.mem_we), 32'd0);
`else
    if (trailer == 8'h00 && exp_err) $display("note: unused trailer");
`endif
    check("fin_done",  32'(bus.done),     32'd1);
    check("fin_ready", 32'(bus.in_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("fin_err",   32'(bus.err),      32'(exp_err));
`else
    check("fin_err",   32'(bus.err),      32'd0);
`endif
    tick();
    check("fin_busy", 32'(bus.busy),   32'd0);
    check("fin_we",   32'(bus.mem_we), 32'd0);
    check("fin_done2", 32'(bus.done),  32'd1);
  endtask

  initial begin
    logic [7:0] bytes [4];
    int unsigned gaps [4];
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    gaps  = '{0, 2, 0, 1};
    #12;
    check("rst_we",    32'(bus.mem_we),   32'd0);
    check("rst_addr",  bus.mem_addr,      32'd0);
    check("rst_wd",    bus.mem_wd,        32'd0);
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    check("rst_err",   32'(bus.err),      32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("idle_ready", 32'(bus.in_ready), 32'd0);
    check("idle_we",    32'(bus.mem_we),   32'd0);

    // back-to-back load
    do_start();
    for (int i = 0; i < 4; i++) send(bytes[i], 32'd100 + 32'(i));
    finish(8'hAA, 1'b0);
    check("hold_addr", bus.mem_addr, 32'd103);
    check("hold_wd",   bus.mem_wd,   32'h44);

    // valid with gaps
    do_start();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(gaps[i]); g++) begin
        tick();
        check("gap_we",   32'(bus.mem_we), 32'd0);
        check("gap_addr", bus.mem_addr,    32'd100 + 32'(i) - 32'd1);
      end
      send(bytes[i], 32'd100 + 32'(i));
    end
    finish(8'hAA, 1'b0);

    // reset mid-load
    do_start();
    send(8'h11, 32'd100);
    send(8'h22, 32'd101);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we",    32'(bus.mem_we),   32'd0);
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_addr",  bus.mem_addr,      32'd0);
    check("mid_rst_done",  32'(bus.done),     32'd0);
    #2 rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_ready", 32'(bus.in_ready), 32'd0);
    check("post_rst_we",    32'(bus.mem_we),   32'd0);
    do_start();
    for (int i = 0; i < 4; i++) send(8'(i + 1), 32'd100 + 32'(i));
    finish(8'h0A, 1'b0);

    // start ignored mid-load, bytes ignored in DONE
    do_start();
    send(8'h11, 32'd100);
    bus.start = 1'b1;
    send(8'h22, 32'd101);
    bus.start = 1'b0;
    check("nostart_ready", 32'(bus.in_ready), 32'd1);
    send(8'h33, 32'd102);
    send(8'h44, 32'd103);
    finish(8'hAA, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_we",    32'(bus.mem_we),   32'd0);
      check("done_ready", 32'(bus.in_ready), 32'd0);
      check("done_level", 32'(bus.done),     32'd1);
      check("done_addr",  bus.mem_addr,      32'd103);
    end
    bus.in_valid = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    do_start();
    for (int i = 0; i < 4; i++) send(8'(i + 1), 32'd100 + 32'(i));
    finish(8'h0B, 1'b1);
    do_start();
    for (int i = 0; i < 4; i++) send(8'(i + 1), 32'd100 + 32'(i));
    finish(8'h0A, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The module SHALL have parameter IMG_BYTES, default 152100, the number of image bytes written per load.
REQ-002 The module SHALL have parameter BASE_ADDR, default 0, the byte address of the first image byte in data memory.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a load; sampled at rising edge.
REQ-006 in_valid  input  1  in_data holds a valid byte from the serial receiver.
REQ-007 in_data  input  8  incoming image byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  data-memory write enable.
REQ-010 mem_addr  output  32  data-memory byte address.
REQ-011 mem_wd  output  32  data-memory write data, {24'b0, byte}.
REQ-012 busy  output  1  load in progress; CPU held off the memory bus.
REQ-013 done  output  1  last load completed.
REQ-014 err  output  1  last load failed its checksum.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, CHECK (only when LOADER_CHECKSUM_EN is defined) and DONE.
REQ-016 IDLE or DONE with start=1 SHALL go to LOAD, clear the byte counter, done and err.
REQ-017 start while in LOAD or CHECK SHALL be ignored.
REQ-018 in_ready SHALL be 1 exactly in LOAD and CHECK, combinationally from state only.
REQ-019 A byte is accepted when in_valid and in_ready are both 1 at a rising edge; the upstream source holds in_data until acceptance.
REQ-020 On acceptance in LOAD, the next cycle SHALL show mem_we=1, mem_addr=BASE_ADDR+count and mem_wd={24'b0,in_data}; count then increments.
REQ-021 Latency is one cycle; mem_addr and mem_wd stay stable for the whole high cycle so that the memory's falling-edge write captures them.
REQ-022 mem_we SHALL be 1 for exactly one cycle per accepted LOAD byte; back-to-back acceptance gives back-to-back writes at consecutive addresses.
REQ-023 Without acceptance, mem_we=0 and mem_addr/mem_wd hold their last values.
REQ-024 Acceptance at count=IMG_BYTES-1 SHALL go to CHECK if LOADER_CHECKSUM_EN is defined, otherwise to DONE; count never exceeds IMG_BYTES-1 and never wraps.
REQ-025 busy SHALL be 1 in LOAD and CHECK, and stay 1 during the cycle carrying the final mem_we pulse.
REQ-026 done SHALL be 1 in DONE, as a level held until the next start.
REQ-027 Bytes presented in IDLE or DONE SHALL NOT be accepted (in_ready=0).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, count 0, mem_we 0, mem_addr 0, mem_wd 0, busy 0, done 0, err 0 and in_ready 0, including in the middle of a load.
REQ-029 After rst_n deasserts, the loader SHALL stay in IDLE until start.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, the loader SHALL keep an 8-bit running sum (mod 256) of the accepted image bytes.
REQ-031 In CHECK it SHALL accept one trailing byte and not write it to memory (mem_we=0).
REQ-032 It SHALL then set err=1 if that byte differs from the sum, else err=0, and go to DONE.
REQ-033 Without LOADER_CHECKSUM_EN, the CHECK state and the sum register SHALL NOT exist, and err is tied to 0.

Verification
REQ-034 IMG_BYTES=4, BASE_ADDR=100, start, bytes 0x11,0x22,0x33,0x44 back-to-back -> four consecutive mem_we pulses at addresses 100..103, mem_wd=0x00000011..0x00000044, then done=1 and busy=0.
REQ-035 in_valid toggled 1,0,0,1 across bytes -> mem_we is only pulsed the cycle after each acceptance; addresses stay consecutive with no gaps or duplicates.
REQ-036 rst_n pulled low after 2 of 4 bytes -> mem_we=0 and busy=0 immediately; a new start writes again from BASE_ADDR.
REQ-037 start asserted mid-load, and bytes presented in DONE -> no restart; in_ready=0 in DONE; no extra mem_we pulses.
REQ-038 With LOADER_CHECKSUM_EN, bytes 0x01,0x02,0x03,0x04 followed by trailing 0x0A -> err=0; with trailing 0x0B -> err=1; in both cases the trailing byte produces no mem_we.
